ram_access_ctrl: RTL and testbench
==================================

# ram_access_ctrl

Request-side sequencer that sits directly upstream of a word array built from `RAM1x2bit` cells. It accepts one read or write request at a time over a valid/ready handshake and decodes the address into one-hot per-word `Write_Select`, `Read_Select_1` and `Read_Select_2` strobes. For reads, it captures and muxes the two addressed words and returns them on a response handshake.

## Interface
- `WORDS`, default 4: number of words in the array. Range 2..16.
- `ADDR_W`, default 2: address width. Must satisfy 2^ADDR_W >= WORDS.
- `DATA_W`, default 2: word width.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high. One clock, one reset; polarity and synchronicity are fixed.
- `req_valid`  in  1  a request is present.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = write, 0 = dual read.
- `req_addr_a`  in  ADDR_W  write address, or port-1 read address.
- `req_addr_b`  in  ADDR_W  port-2 read address; ignored on writes.
- `req_wdata`  in  DATA_W  write data.
- `Write_Data`  out  DATA_W  shared write bus to all words.
- `Write_Select`  out  WORDS  one-hot word write strobe.
- `Read_Select_1`  out  WORDS  one-hot port-1 read strobe.
- `Read_Select_2`  out  WORDS  one-hot port-2 read strobe.
- `mem_rdata_1`  in  WORDS*DATA_W  port-1 outputs of all words, concatenated; word i at bits [i*DATA_W +: DATA_W].
- `mem_rdata_2`  in  WORDS*DATA_W  port-2 outputs of all words, same packing.
- `rsp_valid`  out  1  read response valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data_1`  out  DATA_W  word at `req_addr_a`.
- `rsp_data_2`  out  DATA_W  word at `req_addr_b`.

## Operation
- FSM states: IDLE, WRITE, READ, RESP. All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- IDLE:
  - `req_ready`=1. Accept occurs when `req_valid`&&`req_ready`.
  - On accept, latch the address(es) and `req_wdata`.
  - Go to WRITE if `req_write`=1, else to READ.
- WRITE (one cycle):
  - `Write_Select` = onehot(addr_a); `Write_Data` = latched data.
  - The word captures on the closing edge. Next state is IDLE.
  - Writes produce no response.
- READ (one cycle):
  - `Read_Select_1` = onehot(addr_a); `Read_Select_2` = onehot(addr_b).
  - On the closing edge, capture `mem_rdata_1` word[addr_a] into `rsp_data_1` and `mem_rdata_2` word[addr_b] into `rsp_data_2`.
  - Muxing uses the latched addresses, not the strobes. Next state is RESP.
- RESP:
  - `rsp_valid`=1. Data is held stable until `rsp_valid`&&`rsp_ready`, then IDLE.
  - `req_ready`=0 throughout.
- Outside WRITE, `Write_Select`=0. Outside READ, both read selects = 0. Strobes are never asserted together.
- An address >= WORDS generates an all-zero select. A write to it is dropped; a read of it returns 0 on that port.
- If addr_a == addr_b on a read, both strobes select the same word and both responses carry the same data.
- `Write_Data` holds its last value outside WRITE and has no functional effect there.
- Reset:
  - Priority over everything.
  - Next state is IDLE. All select outputs, `rsp_valid`, `rsp_data_1/2` and `Write_Data` go to 0.
  - `req_ready`=1 from the first cycle after reset deasserts.
  - A request in flight is discarded with no response.
  - Reset asserted during WRITE forces `Write_Select` to 0 at that edge. The downstream word is also in reset, so its reset wins.

## Timing
- Accept at edge E0 -> WRITE or READ strobes are valid for the single cycle E0..E1.
- Write:
  - Committed in the array at E1.
  - `req_ready` is back to 1 after E1.
  - Peak rate is one write per 2 cycles.
- Read:
  - `rsp_valid` rises after E1, giving 2-cycle request-to-response latency.
  - With `rsp_ready` held at 1, the response lasts one cycle and the next accept is possible at E3 (one read per 3 cycles).
- Read-after-write: the earliest following accept is E2, which observes the new data.
- `rsp_ready`=0 stalls indefinitely in RESP; data must not change.

## Test plan
- Reset with all inputs driven to 1 -> all selects=0, `rsp_valid`=0, `rsp_data_1/2`=0, `req_ready`=1 the cycle after release.
- Write 2'b10 to addr 1, then read a=1, b=0 -> `Write_Select`=4'b0010 for exactly one cycle; response `rsp_data_1`=2'b10, `rsp_data_2`=reset value 2'b00, 2 cycles after accept.
- Back-to-back writes of 2'b01, 2'b11, 2'b10, 2'b00 to addrs 0..3 with `req_valid` held high -> accepts spaced 2 cycles apart; a following read a=3, b=2 returns 2'b00 and 2'b10.
- Read with `rsp_ready`=0 for 5 cycles -> `rsp_valid` and data stable and `req_ready`=0 for all 5 cycles; IDLE one cycle after `rsp_ready`=1.
- WORDS=3, write to addr 3 then read a=3, b=2 -> `Write_Select`=0 throughout; `rsp_data_1`=0; `rsp_data_2`=contents of word 2.
- Reset asserted during READ and again during WRITE -> no `rsp_valid`, no write commit, FSM in IDLE after release.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// Request sequencer for a word array of RAM1x2bit cells: one write or dual read at a time,
// one-hot strobe decode, and registered read response on a valid/ready handshake.
module ram_access_ctrl #(
   parameter int unsigned WORDS  = 4,
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned DATA_W = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_W-1:0]         req_addr_a,
   input  logic [ADDR_W-1:0]         req_addr_b,
   input  logic [DATA_W-1:0]         req_wdata,
   output logic [DATA_W-1:0]         Write_Data,
   output logic [WORDS-1:0]          Write_Select,
   output logic [WORDS-1:0]          Read_Select_1,
   output logic [WORDS-1:0]          Read_Select_2,
   input  logic [WORDS*DATA_W-1:0]   mem_rdata_1,
   input  logic [WORDS*DATA_W-1:0]   mem_rdata_2,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_data_1,
   output logic [DATA_W-1:0]         rsp_data_2
);

   typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

   state_e              r_state;
   state_e              w_state_next;
   logic [ADDR_W-1:0]   r_addr_a;
   logic [ADDR_W-1:0]   r_addr_b;
   logic [DATA_W-1:0]   r_write_data;
   logic [DATA_W-1:0]   r_rsp_data_1;
   logic [DATA_W-1:0]   r_rsp_data_2;
   logic [WORDS-1:0]    w_sel_a;
   logic [WORDS-1:0]    w_sel_b;
   logic [DATA_W-1:0]   w_rd_1;
   logic [DATA_W-1:0]   w_rd_2;
   logic                w_accept;

   assign w_accept = (r_state == StIdle) && req_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (req_valid) w_state_next = req_write ? StWrite : StRead;
         StWrite: w_state_next = StIdle;
         StRead:  w_state_next = StResp;
         StResp:  if (rsp_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Out-of-range addresses match no word, so they decode to an all-zero select and mux to 0.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      w_rd_1  = '0;
      w_rd_2  = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (r_addr_a == ADDR_W'(i)) begin
            w_sel_a[i] = 1'b1;
            w_rd_1     = mem_rdata_1[i*DATA_W +: DATA_W];
         end
         if (r_addr_b == ADDR_W'(i)) begin
            w_sel_b[i] = 1'b1;
            w_rd_2     = mem_rdata_2[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr_a     <= '0;
         r_addr_b     <= '0;
         r_write_data <= '0;
         r_rsp_data_1 <= '0;
         r_rsp_data_2 <= '0;
      end else begin
         if (w_accept) begin
            r_addr_a <= req_addr_a;
            r_addr_b <= req_addr_b;
            if (req_write) r_write_data <= req_wdata;
         end
         if (r_state == StRead) begin
            r_rsp_data_1 <= w_rd_1;
            r_rsp_data_2 <= w_rd_2;
         end
      end
   end

   always_comb begin
      req_ready     = (r_state == StIdle);
      rsp_valid     = (r_state == StResp);
      Write_Select  = (r_state == StWrite) ? w_sel_a : '0;
      Read_Select_1 = (r_state == StRead)  ? w_sel_a : '0;
      Read_Select_2 = (r_state == StRead)  ? w_sel_b : '0;
      Write_Data    = r_write_data;
      rsp_data_1    = r_rsp_data_1;
      rsp_data_2    = r_rsp_data_2;
   end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl with a 3-word array, so address 3 exercises the out-of-range path.
module tb_ram_access_ctrl;

   localparam int unsigned W  = 3;
   localparam int unsigned AW = 2;
   localparam int unsigned DW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid, req_ready, req_write;
   logic [AW-1:0]     req_addr_a, req_addr_b;
   logic [DW-1:0]     req_wdata, Write_Data;
   logic [W-1:0]      Write_Select, Read_Select_1, Read_Select_2;
   logic [W*DW-1:0]   mem_rdata_1, mem_rdata_2;
   logic              rsp_valid, rsp_ready;
   logic [DW-1:0]     rsp_data_1, rsp_data_2;

   int unsigned       vectors = 0;
   int unsigned       miscompares = 0;

   // Array emulation (environment) and expected contents (reference).
   logic [DW-1:0]     arr [W];
   logic [DW-1:0]     ref_mem [W];
   logic              mem_ones = 1'b0;

   always #5 clk = ~clk;

   ram_access_ctrl #(.WORDS(W), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_addr_a    (req_addr_a),
      .req_addr_b    (req_addr_b),
      .req_wdata     (req_wdata),
      .Write_Data    (Write_Data),
      .Write_Select  (Write_Select),
      .Read_Select_1 (Read_Select_1),
      .Read_Select_2 (Read_Select_2),
      .mem_rdata_1   (mem_rdata_1),
      .mem_rdata_2   (mem_rdata_2),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data_1    (rsp_data_1),
      .rsp_data_2    (rsp_data_2)
   );

   always_ff @(posedge clk) begin
      for (int i = 0; i < W; i++) begin
         if (reset) arr[i] <= '0;
         else if (Write_Select[i]) arr[i] <= Write_Data;
      end
   end

   // Each word drives its port only while selected.
   always_comb begin
      mem_rdata_1 = '0;
      mem_rdata_2 = '0;
      for (int i = 0; i < W; i++) begin
         if (mem_ones || Read_Select_1[i]) mem_rdata_1[i*DW +: DW] = mem_ones ? '1 : arr[i];
         if (mem_ones || Read_Select_2[i]) mem_rdata_2[i*DW +: DW] = mem_ones ? '1 : arr[i];
      end
   end

   function automatic logic [W-1:0] oh(input logic [AW-1:0] a);
      logic [W-1:0] one;
      one = {{(W-1){1'b0}}, 1'b1};
      return (int'(a) < W) ? (one << a) : '0;
   endfunction

   function automatic logic [DW-1:0] expect_word(input logic [AW-1:0] a);
      return (int'(a) < W) ? ref_mem[a] : '0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_ref();
      for (int i = 0; i < W; i++) ref_mem[i] = '0;
   endtask

   // Tasks start and end at a negedge with the controller idle.
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      check("wr_ready_pre", req_ready, 1);
      req_valid = 1'b1; req_write = 1'b1; req_addr_a = a;
      req_addr_b = AW'($urandom); req_wdata = d;
      @(posedge clk); #1 req_valid = 1'b0; req_write = 1'b0;
      @(negedge clk);
      check("wr_sel", Write_Select, oh(a));
      check("wr_data", Write_Data, d);
      check("wr_rdsel", {Read_Select_1, Read_Select_2}, 0);
      check("wr_ready_busy", req_ready, 0);
      if (int'(a) < W) ref_mem[a] = d;
      @(negedge clk);
      check("wr_sel_off", Write_Select, 0);
      check("wr_ready_post", req_ready, 1);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b, input int stall);
      logic [DW-1:0] e1, e2;
      check("rd_ready_pre", req_ready, 1);
      req_valid = 1'b1; req_write = 1'b0; req_addr_a = a; req_addr_b = b;
      req_wdata = DW'($urandom);
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      check("rd_sel1", Read_Select_1, oh(a));
      check("rd_sel2", Read_Select_2, oh(b));
      check("rd_wrsel", Write_Select, 0);
      check("rd_valid_early", rsp_valid, 0);
      e1 = expect_word(a);
      e2 = expect_word(b);
      @(negedge clk);
      for (int s = 0; s <= stall; s++) begin
         check("rsp_valid", rsp_valid, 1);
         check("rsp_data_1", rsp_data_1, e1);
         check("rsp_data_2", rsp_data_2, e2);
         check("rsp_ready_busy", req_ready, 0);
         check("rsp_sels", {Write_Select, Read_Select_1, Read_Select_2}, 0);
         rsp_ready = (s == stall);
         @(posedge clk); #1 rsp_ready = 1'b0;
         @(negedge clk);
      end
      check("rsp_done", rsp_valid, 0);
      check("rsp_idle_ready", req_ready, 1);
   endtask

   initial begin
      logic [AW-1:0] ra, rb;
      logic [DW-1:0] rd;

      clear_ref();
      // Reset with every input driven high.
      reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; rsp_ready = 1'b1;
      req_addr_a = '1; req_addr_b = '1; req_wdata = '1; mem_ones = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sels", {Write_Select, Read_Select_1, Read_Select_2}, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", {rsp_data_1, rsp_data_2}, 0);
      check("rst_wdata", Write_Data, 0);
      @(posedge clk); #1;
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
      req_addr_a = '0; req_addr_b = '0; req_wdata = '0; mem_ones = 1'b0;
      @(negedge clk);
      check("rst_release_ready", req_ready, 1);

      // Write then read back alongside an untouched word.
      do_write(2'd1, 2'b10);
      do_read(2'd1, 2'd0, 0);

      // Back-to-back writes with req_valid held high; address 3 is out of range here.
      req_valid = 1'b1; req_write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr_a = AW'(i);
         req_wdata  = (i == 0) ? 2'b01 : (i == 1) ? 2'b11 : (i == 2) ? 2'b10 : 2'b00;
         check("b2b_ready", req_ready, 1);
         @(posedge clk);
         @(negedge clk);
         check("b2b_sel", Write_Select, oh(AW'(i)));
         check("b2b_busy", req_ready, 0);
         if (i < W) ref_mem[i] = req_wdata;
         @(posedge clk);
         @(negedge clk);
      end
      req_valid = 1'b0; req_write = 1'b0;
      check("b2b_sel_off", Write_Select, 0);
      do_read(2'd3, 2'd2, 0);

      // Stalled response.
      do_read(2'd0, 2'd1, 5);

      // Out-of-range write must not disturb anything; same-address dual read.
      do_write(2'd3, 2'b11);
      do_read(2'd3, 2'd2, 0);
      do_read(2'd2, 2'd2, 1);

      // Reset during READ.
      req_valid = 1'b1; req_write = 1'b0; req_addr_a = 2'd0; req_addr_b = 2'd1;
      @(posedge clk); #1 req_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      clear_ref();
      @(negedge clk);
      check("rstrd_valid", rsp_valid, 0);
      check("rstrd_data", {rsp_data_1, rsp_data_2}, 0);
      check("rstrd_ready", req_ready, 1);
      @(negedge clk);
      check("rstrd_valid_later", rsp_valid, 0);

      // Reset during WRITE.
      do_write(2'd0, 2'b01);
      req_valid = 1'b1; req_write = 1'b1; req_addr_a = 2'd2; req_wdata = 2'b11;
      @(posedge clk); #1 req_valid = 1'b0; req_write = 1'b0; reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      clear_ref();
      @(negedge clk);
      check("rstwr_sel", Write_Select, 0);
      check("rstwr_ready", req_ready, 1);
      do_read(2'd2, 2'd0, 0);

      // Randomized traffic against the reference contents.
      for (int n = 0; n < 40; n++) begin
         ra = AW'($urandom);
         rb = AW'($urandom);
         rd = DW'($urandom);
         if ($urandom_range(0, 1) == 1) do_write(ra, rd);
         else do_read(ra, rb, int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
